// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush, hold
// and WB->ID write-through. Define HAZARD_PERF_EN to add bubble/flush event counters.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic [4:0]           id_rd_i,
  input  logic [XLEN-1:0]      id_rs1_data_i,
  input  logic [XLEN-1:0]      id_rs2_data_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic [6+ALUOP_W-1:0] id_ctrl_i,
  input  logic                 wb_reg_write_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 flush_i,
  input  logic                 mem_stall_i,
`ifdef HAZARD_PERF_EN
  output logic [31:0]          perf_bubbles_o,
  output logic [31:0]          perf_flushes_o,
`endif
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 ex_valid_o,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [4:0]           ex_rs1_o,
  output logic [4:0]           ex_rs2_o,
  output logic [4:0]           ex_rd_o,
  output logic [XLEN-1:0]      ex_rs1_data_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic [6+ALUOP_W-1:0] ex_ctrl_o
);
  localparam int CW     = 6 + ALUOP_W;
  localparam int MR_BIT = ALUOP_W + 4;  // mem_read position inside ctrl

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [CW-1:0]   ctrl;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic load_use;
  logic take_bubble, take_flush;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign load_use = ex_q.valid & ex_q.ctrl[MR_BIT] & (ex_q.rd != 5'd0) & id_valid_i &
                    ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));

  // Same-cycle WB write would otherwise be missed by the regfile read in ID.
  assign rs1_fwd = (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == id_rs1_i) ? wb_data_i : id_rs1_data_i;
  assign rs2_fwd = (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == id_rs2_i) ? wb_data_i : id_rs2_data_i;

  always_comb begin
    ex_d          = ex_q;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    take_bubble   = 1'b0;
    take_flush    = 1'b0;
    if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (flush_i) begin
      ex_d       = '0;
      take_flush = 1'b1;
    end else if (load_use) begin
      ex_d          = '0;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      take_bubble   = 1'b1;
    end else begin
      ex_d.valid    = id_valid_i;
      ex_d.pc       = id_pc_i;
      ex_d.rs1      = id_rs1_i;
      ex_d.rs2      = id_rs2_i;
      ex_d.rd       = id_rd_i;
      ex_d.rs1_data = rs1_fwd;
      ex_d.rs2_data = rs2_fwd;
      ex_d.imm      = id_imm_i;
      ex_d.ctrl     = id_valid_i ? id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_bubbles_q, perf_flushes_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (take_bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (take_flush)  perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end
  assign perf_bubbles_o = perf_bubbles_q;
  assign perf_flushes_o = perf_flushes_q;
`else
  logic unused_perf;
  assign unused_perf = take_bubble ^ take_flush;
`endif

  assign ex_valid_o    = ex_q.valid;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_ctrl_o     = ex_q.ctrl;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf counter checks compile in with HAZARD_PERF_EN.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CW   = 10;
  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[3:0]}
  localparam logic [CW-1:0] C_ALU  = 10'h202;  // reg_write, alu_op=2
  localparam logic [CW-1:0] C_LOAD = 10'h340;  // reg_write, mem_read, mem_to_reg

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, wb_reg_write, flush, mem_stall;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [CW-1:0] id_ctrl;
  logic pc_write, if_id_write, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] ex_ctrl;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
    .wb_reg_write_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush), .mem_stall_i(mem_stall),
`ifdef HAZARD_PERF_EN
    .perf_bubbles_o(perf_bubbles), .perf_flushes_o(perf_flushes),
`endif
    .pc_write_o(pc_write), .if_id_write_o(if_id_write), .ex_valid_o(ex_valid),
    .ex_pc_o(ex_pc), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [CW-1:0] c);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0; mem_stall = 0;
    #3;
    n_cmp++; if ({ex_valid, ex_rd, ex_ctrl} !== 16'h0) begin n_err++; $display("FAIL reset_ex got v=%0b rd=%0d ctrl=%h exp 0", ex_valid, ex_rd, ex_ctrl); end
    n_cmp++; if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== 128'h0) begin n_err++; $display("FAIL reset_data got pc=%h d1=%h d2=%h imm=%h exp 0", ex_pc, ex_rs1_data, ex_rs2_data, ex_imm); end
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_err++; $display("FAIL reset_pcw got %b exp 11", {pc_write, if_id_write}); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if ({perf_bubbles, perf_flushes} !== 64'h0) begin n_err++; $display("FAIL reset_perf got %h/%h exp 0", perf_bubbles, perf_flushes); end
`endif
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_alu();
    set_id(1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h4, C_ALU);
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL alu_pcw got %b exp 1", pc_write); end
    tick();
    n_cmp++; if ({ex_valid, ex_rd, ex_rs1, ex_rs2} !== {1'b1, 5'd5, 5'd1, 5'd2}) begin n_err++; $display("FAIL alu_idx got v=%b rd=%0d rs1=%0d rs2=%0d exp 1/5/1/2", ex_valid, ex_rd, ex_rs1, ex_rs2); end
    n_cmp++; if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl} !== {32'h100, 32'h11, 32'h22, 32'h4, C_ALU}) begin n_err++; $display("FAIL alu_data got pc=%h d1=%h d2=%h imm=%h ctrl=%h", ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl); end
  endtask

  task automatic test_load_use();
    set_id(1, 32'h104, 5'd1, 5'd2, 5'd7, 0, 0, 32'h8, C_LOAD);
    tick();
    set_id(1, 32'h108, 5'd4, 5'd7, 5'd8, 32'h44, 32'h77, 0, C_ALU);
    #1;
    n_cmp++; if ({pc_write, if_id_write} !== 2'b00) begin n_err++; $display("FAIL lu_stall got %b exp 00", {pc_write, if_id_write}); end
    tick();
    n_cmp++; if ({ex_valid, ex_ctrl, ex_rd} !== 16'h0) begin n_err++; $display("FAIL lu_bubble got v=%b ctrl=%h rd=%0d exp 0", ex_valid, ex_ctrl, ex_rd); end
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_err++; $display("FAIL lu_clear got %b exp 11", {pc_write, if_id_write}); end
    tick();
    n_cmp++; if ({ex_valid, ex_rd, ex_rs1_data, ex_pc} !== {1'b1, 5'd8, 32'h44, 32'h108}) begin n_err++; $display("FAIL lu_reissue got v=%b rd=%0d d1=%h pc=%h exp 1/8/44/108", ex_valid, ex_rd, ex_rs1_data, ex_pc); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if (perf_bubbles !== 32'd1) begin n_err++; $display("FAIL lu_perf got %0d exp 1", perf_bubbles); end
`endif
  endtask

  task automatic test_x0_load();
    set_id(1, 32'h10c, 5'd1, 5'd2, 5'd0, 0, 0, 0, C_LOAD);
    tick();
    set_id(1, 32'h110, 5'd0, 5'd3, 5'd9, 32'h5, 32'h6, 0, C_ALU);
    #1;
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_err++; $display("FAIL x0_nostall got %b exp 11", {pc_write, if_id_write}); end
    // load to x12 but ID invalid: no stall either
    set_id(1, 32'h110, 5'd1, 5'd2, 5'd12, 0, 0, 0, C_LOAD);
    tick();
    set_id(0, 32'h114, 5'd12, 5'd12, 5'd13, 0, 0, 0, C_ALU);
    #1;
    n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL invalid_nostall got %b exp 1", pc_write); end
    tick();
    n_cmp++; if ({ex_valid, ex_ctrl} !== 11'h0) begin n_err++; $display("FAIL invalid_ctrl got v=%b ctrl=%h exp 0", ex_valid, ex_ctrl); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 32'h200, 5'd1, 5'd2, 5'd9, 0, 0, 0, C_LOAD);
    tick();
    set_id(1, 32'h204, 5'd9, 5'd2, 5'd10, 32'h99, 0, 0, C_ALU);
    flush = 1;
    #1;
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_err++; $display("FAIL flush_pcw got %b exp 11", {pc_write, if_id_write}); end
    tick();
    flush = 0;
    n_cmp++; if ({ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2} !== 26'h0) begin n_err++; $display("FAIL flush_bubble got v=%b ctrl=%h rd=%0d rs1=%0d rs2=%0d exp 0", ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2); end
`ifdef HAZARD_PERF_EN
    n_cmp++; if ({perf_flushes, perf_bubbles} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL flush_perf got fl=%0d bu=%0d exp 1/0", perf_flushes, perf_bubbles); end
`endif
  endtask

  task automatic test_mem_stall();
    set_id(1, 32'h300, 5'd1, 5'd2, 5'd10, 32'hAAA, 32'hBBB, 32'hC, C_ALU);
    tick();
    set_id(1, 32'h400, 5'd3, 5'd4, 5'd11, 32'h111, 32'h222, 32'h0, C_LOAD);
    mem_stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({pc_write, if_id_write} !== 2'b00) begin n_err++; $display("FAIL stall_pcw[%0d] got %b exp 00", i, {pc_write, if_id_write}); end
      tick();
      n_cmp++; if ({ex_valid, ex_rd, ex_pc, ex_rs1_data, ex_ctrl} !== {1'b1, 5'd10, 32'h300, 32'hAAA, C_ALU}) begin n_err++; $display("FAIL stall_hold[%0d] got v=%b rd=%0d pc=%h d1=%h ctrl=%h", i, ex_valid, ex_rd, ex_pc, ex_rs1_data, ex_ctrl); end
    end
`ifdef HAZARD_PERF_EN
    n_cmp++; if ({perf_flushes, perf_bubbles} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL stall_perf got fl=%0d bu=%0d exp 1/0", perf_flushes, perf_bubbles); end
`endif
    mem_stall = 0; flush = 0;
    tick();
    n_cmp++; if ({ex_valid, ex_rd, ex_pc, ex_ctrl} !== {1'b1, 5'd11, 32'h400, C_LOAD}) begin n_err++; $display("FAIL stall_release got v=%b rd=%0d pc=%h ctrl=%h", ex_valid, ex_rd, ex_pc, ex_ctrl); end
    set_id(1, 32'h404, 5'd1, 5'd2, 5'd14, 0, 0, 0, C_ALU);  // no dependence on x11
    tick();
  endtask

  task automatic test_write_through();
    set_id(1, 32'h500, 5'd3, 5'd6, 5'd15, 32'h0, 32'h66, 0, C_ALU);
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    n_cmp++; if ({ex_rs1_data, ex_rs2_data} !== {32'hDEADBEEF, 32'h66}) begin n_err++; $display("FAIL wt_rs1 got %h/%h exp deadbeef/66", ex_rs1_data, ex_rs2_data); end
    wb_rd = 5'd6;
    tick();
    n_cmp++; if ({ex_rs1_data, ex_rs2_data} !== {32'h0, 32'hDEADBEEF}) begin n_err++; $display("FAIL wt_rs2 got %h/%h exp 0/deadbeef", ex_rs1_data, ex_rs2_data); end
    set_id(1, 32'h504, 5'd0, 5'd0, 5'd15, 32'h123, 32'h456, 0, C_ALU);
    wb_rd = 5'd0;
    tick();
    n_cmp++; if ({ex_rs1_data, ex_rs2_data} !== {32'h123, 32'h456}) begin n_err++; $display("FAIL wt_x0 got %h/%h exp 123/456", ex_rs1_data, ex_rs2_data); end
    wb_reg_write = 0;
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 32'h600, 5'd1, 5'd2, 5'd20, 0, 0, 0, C_LOAD);
    tick();
    set_id(1, 32'h604, 5'd20, 5'd2, 5'd21, 32'h1, 0, 0, C_ALU);
    mem_stall = 1;
    #2;
    rst_n = 1'b0; mem_stall = 0;
    #1;
    n_cmp++; if ({ex_valid, ex_rd, ex_ctrl, ex_pc} !== 48'h0) begin n_err++; $display("FAIL rst_mid got v=%b rd=%0d ctrl=%h pc=%h exp 0", ex_valid, ex_rd, ex_ctrl, ex_pc); end
    n_cmp++; if ({pc_write, if_id_write} !== 2'b11) begin n_err++; $display("FAIL rst_mid_pcw got %b exp 11", {pc_write, if_id_write}); end
    tick(); rst_n = 1'b1;
    tick();
    n_cmp++; if ({ex_valid, ex_rd} !== {1'b1, 5'd21}) begin n_err++; $display("FAIL rst_after got v=%b rd=%0d exp 1/21", ex_valid, ex_rd); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_x0_load();
    test_flush();
    test_mem_stall();
    test_write_through();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, bubble insertion, flush and hold.
- Captures decoded operands and control from ID and presents them to EX.
- Its registered ex_rs1/ex_rs2 drive the forwarding unit's rs1/rs2 inputs; its ex_rd/ex_reg_write become EX/MEM's rd/RegWrite one cycle later.
- Also performs WB→ID register-file write-through so same-cycle writebacks are not lost.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, width of ALU operation field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1  in  5  source reg 1 index
id_rs2  in  5  source reg 2 index
id_rd  in  5  destination index
id_rs1_data  in  XLEN  regfile read data 1
id_rs2_data  in  XLEN  regfile read data 2
id_imm  in  XLEN  decoded immediate
id_ctrl  in  6+ALUOP_W  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
wb_reg_write  in  1  WB stage writing regfile
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
flush  in  1  taken branch/jump resolved in EX
mem_stall  in  1  downstream (memory) not ready; freeze
pc_write  out  1  PC may advance
if_id_write  out  1  IF/ID may load
ex_valid  out  1  EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rs1  out  5  to forwarding unit rs1
ex_rs2  out  5  to forwarding unit rs2
ex_rd  out  5  registered destination
ex_rs1_data  out  XLEN  registered operand 1
ex_rs2_data  out  XLEN  registered operand 2
ex_imm  out  XLEN  registered immediate
ex_ctrl  out  6+ALUOP_W  registered control, same packing as id_ctrl

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, ex_valid=0. pc_write and if_id_write are combinational and follow the rules below with registers at 0. Deassertion is sampled on the next rising edge.
- load_use (combinational) = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Write-through: wb_reg_write & wb_rd!=0 & wb_rd==id_rs1 → capture wb_data as rs1 data, else id_rs1_data. Same rule for rs2. x0 never bypassed.
- Per-edge action, priority highest first:
  1. mem_stall=1: hold all ex_* (flush ignored this cycle; EX resolves it again next cycle). pc_write=0, if_id_write=0.
  2. flush=1: load bubble (ex_valid=0, ex_ctrl=0, ex_rd=0, ex_rs1=ex_rs2=0; data fields don't-care, zeroed). pc_write=1, if_id_write=1 (IF/ID is squashed by its own flush).
  3. load_use=1: load bubble as in 2. pc_write=0, if_id_write=0. ID instruction re-presented next cycle.
  4. else: load ID fields. ex_valid=id_valid. ex_ctrl=id_ctrl if id_valid, else 0. pc_write=1, if_id_write=1.
- Latency: one cycle ID→EX. A load-use costs exactly one bubble; on the following cycle ex_valid=0, so load_use clears automatically.
- Bubble invariant: whenever ex_valid=0, ex_ctrl.reg_write/mem_read/mem_write/branch are 0, so the forwarding unit never matches a bubble.
- Reset mid-stall: all state clears; no pending hazard survives.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_bubbles[31:0] and perf_flushes[31:0], both async-reset to 0.
  - perf_bubbles increments on each edge taking branch 3.
  - perf_flushes increments on each edge taking branch 2.
  - Both wrap modulo 2^32 and both hold during mem_stall.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then plain ALU instr (id_rd=5, reg_write=1, id_rs1_data=0x11) → next edge ex_valid=1, ex_rd=5, ex_rs1_data=0x11; pc_write=1.
- Load to x7 in EX, ID uses rs2=7 → pc_write=0, if_id_write=0, next edge ex_valid=0, ex_ctrl=0. Following edge the ID instr loads normally. Perf build: perf_bubbles=1.
- Load to x0 in EX, ID uses rs1=0 → no stall, pc_write=1.
- flush=1 with load_use also true → bubble loaded, pc_write=1. Perf build: perf_flushes=1, perf_bubbles=0.
- mem_stall=1 for 3 cycles with flush=1 and new ID data → ex_* unchanged for 3 edges; pc_write=0 throughout.
- wb_reg_write=1, wb_rd=3, wb_data=0xDEADBEEF, id_rs1=3, id_rs1_data=0 → ex_rs1_data=0xDEADBEEF. Repeat with wb_rd=0 → ex_rs1_data=id_rs1_data.
